// File: rtl/seq_detect_param.sv
// seq_detect_param: loadable-pattern serial sequence detector with overlap control and saturating match counter
module seq_detect_param #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int OVERLAP = 1,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(5'b10010),
  localparam int SW = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  logic [PAT_W-1:0] pat, hist, nh;
  logic [SW-1:0] vcnt, nv, nk;
  logic match, inc;
  assign cnt_sat = &match_cnt;
  assign inc = en && !load && match;
  // nk is the longest pattern prefix that ends the valid part of the new history
  always_comb begin
    nh = {hist[PAT_W-2:0], x};
    nv = (vcnt == SW'(PAT_W)) ? vcnt : vcnt + SW'(1);
    match = (nv == SW'(PAT_W)) && (nh == pat);
    nk = '0;
    for (int k = 1; k <= PAT_W; k++)
      if (k <= int'(nv) && ((nh ^ (pat >> (PAT_W - k))) & ({PAT_W{1'b1}} >> (PAT_W - k))) == '0)
        nk = SW'(k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= PAT_RST;
      hist <= '0;
      vcnt <= '0;
      state <= '0;
      z <= 1'b0;
      match_cnt <= '0;
    end else begin
      z <= 1'b0;
      if (load) begin
        pat <= pat_in;
        hist <= '0;
        vcnt <= '0;
        state <= '0;
      end else if (en) begin
        z <= match;
        hist <= (match && OVERLAP == 0) ? '0 : nh;
        vcnt <= (match && OVERLAP == 0) ? '0 : nv;
        state <= (match && OVERLAP == 0) ? '0 : nk;
      end
      match_cnt <= cnt_clr ? CNT_W'(inc) : (inc && !cnt_sat) ? match_cnt + CNT_W'(1) : match_cnt;
    end
  end
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: three detector variants (overlap, non-overlap, 2-bit counter) against a prefix-search model
module tb_seq_detect_param;
  logic clk = 0, rst = 0, en = 0, x = 0, load = 0, cnt_clr = 0;
  logic [4:0] pat_in = '0;
  logic z_a, z_b, z_c, sat_a, sat_b, sat_c;
  logic [2:0] st_a, st_b, st_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;
  seq_detect_param u_a (.clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .z(z_a), .state(st_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
  seq_detect_param #(.OVERLAP(0)) u_b (.clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .z(z_b), .state(st_b), .match_cnt(cnt_b), .cnt_sat(sat_b));
  seq_detect_param #(.CNT_W(2)) u_c (.clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .z(z_c), .state(st_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: remember the sampled bits, search the longest suffix that is a pattern prefix
  int mst[3], mz[3], mcnt[3], mvl[3], mm;
  logic [15:0] mh[3];
  logic [4:0] mp;
  int ovs[3] = '{1, 0, 1};
  int maxc[3] = '{255, 255, 3};
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mm = 0;
      if (rst) begin
        mh[i] = 0; mvl[i] = 0; mst[i] = 0; mcnt[i] = 0;
      end else begin
        if (load) begin
          mh[i] = 0; mvl[i] = 0; mst[i] = 0;
        end else if (en) begin
          mh[i] = {mh[i][14:0], x};
          mvl[i] = mvl[i] < 5 ? mvl[i] + 1 : 5;
          mm = (mvl[i] == 5 && mh[i][4:0] == mp) ? 1 : 0;
          if (mm == 1 && ovs[i] == 0) begin
            mh[i] = 0; mvl[i] = 0; mst[i] = 0;
          end else begin
            mst[i] = 0;
            for (int k = 1; k <= mvl[i]; k++)
              if ((int'(mh[i]) & ((1 << k) - 1)) == (int'(mp) >> (5 - k))) mst[i] = k;
          end
        end
        mcnt[i] = cnt_clr ? mm : (mm == 1 && mcnt[i] < maxc[i]) ? mcnt[i] + 1 : mcnt[i];
      end
      mz[i] = mm;
    end
    if (rst) mp = 5'b10010;
    else if (load) mp = pat_in;
  end

  always @(negedge clk) if (chk_on) begin
    chk("z_a", z_a, mz[0]); chk("state_a", st_a, mst[0]); chk("cnt_a", cnt_a, mcnt[0]); chk("sat_a", sat_a, mcnt[0] == 255);
    chk("z_b", z_b, mz[1]); chk("state_b", st_b, mst[1]); chk("cnt_b", cnt_b, mcnt[1]); chk("sat_b", sat_b, mcnt[1] == 255);
    chk("z_c", z_c, mz[2]); chk("state_c", st_c, mst[2]); chk("cnt_c", cnt_c, mcnt[2]); chk("sat_c", sat_c, mcnt[2] == 3);
  end

  task automatic cyc(input logic r, input logic l, input logic e, input logic xb, input logic cc, input logic [4:0] p);
    rst = r; load = l; en = e; x = xb; cnt_clr = cc; pat_in = p;
    @(negedge clk);
  endtask

  int rsa[32], rsb[32], rza[32], rzb[32], rcc[32];
  task automatic run(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 1, bits[n-1-i], 0, '0);
      rsa[i] = st_a; rsb[i] = st_b; rza[i] = z_a; rzb[i] = z_b; rcc[i] = cnt_c;
    end
  endtask

  int esa[8] = '{1, 2, 3, 4, 5, 3, 4, 5};
  int esb[8] = '{1, 2, 3, 4, 0, 0, 1, 2};
  int eza[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  int ezb[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int ecc[4] = '{1, 2, 3, 3};

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, '0);
    chk_on = 1;
    chk("rst_state", st_a, 0); chk("rst_z", z_a, 0); chk("rst_cnt", cnt_a, 0); chk("rst_sat", sat_a, 0);
    // overlap vs non-overlap on 10010010
    run(32'b10010010, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_state_a[%0d]", i), rsa[i], esa[i]);
      chk($sformatf("t2_state_b[%0d]", i), rsb[i], esb[i]);
      chk($sformatf("t1_z_a[%0d]", i), rza[i], eza[i]);
      chk($sformatf("t2_z_b[%0d]", i), rzb[i], ezb[i]);
    end
    chk("t1_cnt_a", cnt_a, 2); chk("t2_cnt_b", cnt_b, 1);
    // enable gaps hold progress
    cyc(1, 0, 0, 0, 0, '0);
    run(32'b100, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1'($urandom_range(0, 1)), 0, '0);
      chk("t3_hold_state", st_a, 3); chk("t3_hold_z", z_a, 0);
    end
    run(32'b10, 2);
    chk("t3_z", rza[1], 1); chk("t3_cnt", cnt_a, 1);
    // reset mid-stream
    cyc(1, 0, 0, 0, 0, '0);
    run(32'b100, 3);
    cyc(1, 0, 0, 0, 0, '0);
    chk("t4_state", st_a, 0);
    run(32'b010, 3);
    chk("t4_z", rza[0] | rza[1] | rza[2], 0); chk("t4_cnt", cnt_a, 0);
    // load 11111 mid-stream
    cyc(1, 0, 0, 0, 0, '0);
    run(32'b11, 2);
    cyc(0, 1, 1, 1, 0, 5'b11111);
    chk("t5_state", st_a, 0);
    run(32'b111111, 6);
    chk("t5_z5", rza[4], 1); chk("t5_z6", rza[5], 1); chk("t5_cnt", cnt_a, 2);
    // saturation of the 2-bit counter, then clear coincident with a match
    cyc(1, 0, 0, 0, 0, '0);
    run(32'b10010010010010, 14);
    chk("t6_c1", rcc[4], ecc[0]); chk("t6_c2", rcc[7], ecc[1]); chk("t6_c3", rcc[10], ecc[2]); chk("t6_c4", rcc[13], ecc[3]);
    chk("t6_sat", sat_c, 1);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 0, 1, 1, 0, '0);
    cyc(0, 0, 1, 0, 1, '0);
    chk("t6_clr_cnt", cnt_c, 1); chk("t6_clr_sat", sat_c, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] p;
      int sel;
      sel = $urandom_range(0, 3);
      p = sel == 0 ? 5'b00000 : sel == 1 ? 5'b11111 : 5'($urandom);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
          1'($urandom), $urandom_range(0, 119) == 0, p);
    end
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-sequence detector. Successor to the fixed 3-bit-state single-pattern detector.
- Adds a runtime-loadable pattern of PAT_W bits, selectable overlap or non-overlap matching, an enable, a progress/state output and a saturating match counter.
- Sits on a 1-bit serial input stream `x`. Feeds match pulses and counts to downstream control/status logic.

Parameters:
- PAT_W, 5, pattern length in bits (2..16).
- CNT_W, 8, match counter width.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- PAT_RST, 5'b10010, pattern register value after reset (PAT_W bits; MSB is the first bit expected).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  sample `x` on this edge when 1; when 0, hold all state.
- x  in  1  serial data bit.
- load  in  1  latch `pat_in` into the pattern register.
- pat_in  in  PAT_W  new pattern (MSB = first bit in time).
- cnt_clr  in  1  clear match counter.
- z  out  1  registered one-cycle match pulse.
- state  out  SW=$clog2(PAT_W+1)  current match progress, 0..PAT_W.
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  match_cnt is at all-ones.

Behaviour:
- Internal registers:
  - `pat` (PAT_W)
  - `hist` (PAT_W shift register)
  - `vcnt` (valid history bits, 0..PAT_W)
  - `state`, `z`, `match_cnt`
- Reset (rst=1 at posedge), highest priority:
  - `pat` = PAT_RST; all other registers cleared.
  - Outputs: z=0, state=0, match_cnt=0, cnt_sat=0.
- Load (load=1, no rst), second priority:
  - `pat` <= pat_in; hist, vcnt, state cleared; z <= 0.
  - `x` is ignored that cycle. match_cnt is unchanged unless cnt_clr is also asserted.
- Sample (en=1, no rst, no load):
  - nh = {hist[PAT_W-2:0], x}
  - nv = min(vcnt+1, PAT_W)
  - match = (nv==PAT_W) && (nh==pat)
  - z <= match, so z is high for exactly the clock cycle following the edge that sampled the completing bit.
  - If match and OVERLAP==0: hist <= 0, vcnt <= 0, state <= 0.
  - Otherwise: hist <= nh, vcnt <= nv, and state <= largest k in 0..nv such that nh[k-1:0] == pat[PAT_W-1 -: k]. In overlap mode a full match therefore reports state=PAT_W.
- Idle (en=0): hist, vcnt, state and match_cnt hold; z <= 0.
- Counter:
  - On match, match_cnt increments unless already all-ones, where it stays.
  - cnt_sat = (match_cnt == all-ones), combinational from the register.
  - cnt_clr with no match: match_cnt <= 0.
  - cnt_clr on the same edge as a match: match_cnt <= 1 (clear then count).
  - cnt_clr works regardless of en. It is overridden only by rst. When load and cnt_clr are both asserted, load handles the pattern and cnt_clr clears the counter.
- Reset mid-stream: partial progress is lost. Detection restarts from an empty history; no match is possible until PAT_W new bits have been sampled.
- All-zero or all-one patterns are legal. The valid-count gate prevents a false match from the cleared history.

Test Plan:
1. OVERLAP=1, pattern 10010, en=1, x = 1,0,0,1,0,0,1,0 → state after each bit = 1,2,3,4,5,3,4,5; z pulses after bits 5 and 8; match_cnt=2.
2. OVERLAP=0, same stream → state = 1,2,3,4,0,0,1,2; z pulses only after bit 5; match_cnt=1.
3. en toggling: stream 1,0,0,1,0 with en=0 for 3 cycles between bits 3 and 4 → state holds 3 and z stays 0 while en=0; match after bit 5; match_cnt=1.
4. Pattern 1,0,0,1,0 with rst asserted after bit 3, then 0,1,0 → state=0 after reset; no z pulse (vcnt<5).
5. load pat_in=5'b11111 mid-stream after bits 1,1 → state=0; then five 1s → z after 5th; a 6th 1 → z again (overlap); match_cnt increments by 2.
6. CNT_W=2, OVERLAP=1, pattern 10010, stream 10010010010010 → match_cnt sequence 1,2,3,3, cnt_sat=1 after 3rd match. Then cnt_clr coincident with a match → match_cnt=1, cnt_sat=0.
